// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the iterative RV32M divider.
// Launches DIV/DIVU/REM/REMU, holds start for the whole operation, stalls the
// pipeline until the divider reports ready, and forwards the result to the
// register-file write port. A flush during RUN aborts the divider cleanly.
module div_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic              ex_is_div_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [DATA_W-1:0] ex_rs1_i,
    input  logic [DATA_W-1:0] ex_rs2_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic              flush_i,
    output logic              div_start_o,
    output logic [DATA_W-1:0] div_dividend_o,
    output logic [DATA_W-1:0] div_divisor_o,
    output logic [2:0]        div_op_o,
    output logic [ADDR_W-1:0] div_waddr_o,
    input  logic              div_ready_i,
    input  logic              div_busy_i,
    input  logic [DATA_W-1:0] div_res_i,
    input  logic [ADDR_W-1:0] div_waddr_i,
    output logic              stall_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StAbort
    } state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ADDR_W-1:0] rd_q;
    logic              req;

    // A flushed instruction never counts as a request.
    assign req = ex_valid_i & ex_is_div_i & ~flush_i;

    // State machine and operand capture on the IDLE->RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && !div_busy_i) begin
                        state_q <= StRun;
                        op_q    <= ex_funct3_i;
                        a_q     <= ex_rs1_i;
                        b_q     <= ex_rs2_i;
                        rd_q    <= ex_rd_i;
                    end
                end
                StRun: begin
                    // Ready wins over flush: the result is already committed.
                    if (div_ready_i) begin
                        state_q <= StIdle;
                    end else if (flush_i) begin
                        state_q <= StAbort;
                    end
                end
                StAbort: begin
                    if (!div_busy_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operand mux: live EX operands while idle so the divider can latch them at the
    // issue edge; registered copies afterwards.
    always_comb begin
        div_op_o       = op_q;
        div_dividend_o = a_q;
        div_divisor_o  = b_q;
        div_waddr_o    = rd_q;
        if (state_q == StIdle) begin
            div_op_o       = ex_funct3_i;
            div_dividend_o = ex_rs1_i;
            div_divisor_o  = ex_rs2_i;
            div_waddr_o    = ex_rd_i;
        end
    end

    // Start, stall and writeback control. Start must fall in the ready cycle or
    // the divider would relatch and restart on its way back to idle.
    always_comb begin
        div_start_o = 1'b0;
        stall_o     = 1'b0;
        wb_we_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                div_start_o = req & ~div_busy_i;
                stall_o     = req;
            end
            StRun: begin
                div_start_o = ~div_ready_i & ~flush_i;
                stall_o     = ~div_ready_i;
                wb_we_o     = div_ready_i & (div_waddr_i != '0);
            end
            StAbort: begin
                stall_o = 1'b1;
            end
            default: ;
        endcase
        wb_waddr_o = div_waddr_i;
        wb_wdata_o = div_res_i;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl. The bench plays the divider: it drives ready,
// busy, result and latched rd at hand-chosen cycles with hand-computed results.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_is_div_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_rs1_i;
    logic [31:0] ex_rs2_i;
    logic [4:0]  ex_rd_i;
    logic        flush_i;
    logic        div_start_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [2:0]  div_op_o;
    logic [4:0]  div_waddr_o;
    logic        div_ready_i;
    logic        div_busy_i;
    logic [31:0] div_res_i;
    logic [4:0]  div_waddr_i;
    logic        stall_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;

    int checks;
    int failures;

    div_ctrl #(
        .DATA_W(32),
        .ADDR_W(5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .ex_is_div_i    (ex_is_div_i),
        .ex_funct3_i    (ex_funct3_i),
        .ex_rs1_i       (ex_rs1_i),
        .ex_rs2_i       (ex_rs2_i),
        .ex_rd_i        (ex_rd_i),
        .flush_i        (flush_i),
        .div_start_o    (div_start_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_op_o       (div_op_o),
        .div_waddr_o    (div_waddr_o),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .div_res_i      (div_res_i),
        .div_waddr_i    (div_waddr_i),
        .stall_o        (stall_o),
        .wb_we_o        (wb_we_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue cycle: present the op in EX with the divider idle.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        ex_valid_i  = 1'b1;
        ex_is_div_i = 1'b1;
        ex_funct3_i = op;
        ex_rs1_i    = a;
        ex_rs2_i    = b;
        ex_rd_i     = rd;
        div_busy_i  = 1'b0;
        div_ready_i = 1'b0;
        #1;
        check({tag, "_start"}, {31'd0, div_start_o}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
        check({tag, "_issue_ops"},
              {div_dividend_o == a, div_divisor_o == b, div_op_o == op, div_waddr_o == rd},
              32'hF);
        step();
    endtask

    // n busy cycles in RUN; EX inputs are scrambled to prove the registered
    // operands are presented.
    task automatic run(input string tag, input int n, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            ex_rs1_i    = 32'hDEAD_BEEF;
            ex_rs2_i    = 32'h1357_9BDF;
            ex_rd_i     = 5'd31;
            ex_funct3_i = 3'b000;
            div_busy_i  = 1'b1;
            div_ready_i = 1'b0;
            #1;
            if (!(div_start_o === 1'b1 && stall_o === 1'b1 && wb_we_o === 1'b0 &&
                  div_dividend_o === a && div_divisor_o === b && div_op_o === op &&
                  div_waddr_o === rd)) begin
                bad++;
            end
            step();
        end
        check({tag, "_run_bad_cycles"}, bad, 32'd0);
    endtask

    // Ready cycle followed by one idle cycle with EX advanced to a non-div op.
    task automatic finish(input string tag, input logic [31:0] res, input logic [4:0] waddr,
                          input logic we_exp);
        div_ready_i = 1'b1;
        div_busy_i  = 1'b0;
        div_res_i   = res;
        div_waddr_i = waddr;
        #1;
        check({tag, "_we"}, {31'd0, wb_we_o}, {31'd0, we_exp});
        check({tag, "_wdata"}, wb_wdata_o, res);
        check({tag, "_waddr"}, {27'd0, wb_waddr_o}, {27'd0, waddr});
        check({tag, "_rdy_start"}, {31'd0, div_start_o}, 32'd0);
        check({tag, "_rdy_stall"}, {31'd0, stall_o}, 32'd0);
        step();
        div_ready_i = 1'b0;
        ex_valid_i  = 1'b0;
        #1;
        check({tag, "_after_idle"}, {29'd0, div_start_o, stall_o, wb_we_o}, 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        ex_valid_i  = 1'b0;
        ex_is_div_i = 1'b0;
        ex_funct3_i = 3'b000;
        ex_rs1_i    = '0;
        ex_rs2_i    = '0;
        ex_rd_i     = '0;
        flush_i     = 1'b0;
        div_ready_i = 1'b0;
        div_busy_i  = 1'b0;
        div_res_i   = '0;
        div_waddr_i = '0;
        step();
        step();
        check("reset_ctrl", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd0);
        rst = 1'b0;
        step();
        check("post_reset_ctrl", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd0);

        // Non-divide instruction in EX does not stall.
        ex_valid_i  = 1'b1;
        ex_is_div_i = 1'b0;
        #1;
        check("non_div_stall", {30'd0, div_start_o, stall_o}, 32'd0);
        // Flushed divide request neither starts nor stalls.
        ex_is_div_i = 1'b1;
        flush_i     = 1'b1;
        #1;
        check("flushed_req", {30'd0, div_start_o, stall_o}, 32'd0);
        flush_i = 1'b0;
        // Spurious ready in IDLE writes nothing.
        ex_valid_i  = 1'b0;
        div_ready_i = 1'b1;
        div_waddr_i = 5'd9;
        #1;
        check("spurious_ready_we", {31'd0, wb_we_o}, 32'd0);
        div_ready_i = 1'b0;
        step();

        // DIV 100/7 -> 14, rd=x5: 35 stall cycles.
        issue("div100_7", 3'b100, 32'd100, 32'd7, 5'd5);
        run("div100_7", 34, 3'b100, 32'd100, 32'd7, 5'd5);
        finish("div100_7", 32'd14, 5'd5, 1'b1);
        step();

        // REM -7 % 2 -> -1.
        issue("rem_m7", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run("rem_m7", 34, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
        finish("rem_m7", 32'hFFFF_FFFF, 5'd6, 1'b1);
        step();
        // DIV -7 / 2 -> -3.
        issue("div_m7", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run("div_m7", 34, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
        finish("div_m7", 32'hFFFF_FFFD, 5'd7, 1'b1);
        step();
        // DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
        issue("divu_big", 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run("divu_big", 34, 3'b101, 32'hFFFF_FFF9, 32'd2, 5'd8);
        finish("divu_big", 32'h7FFF_FFFC, 5'd8, 1'b1);
        step();

        // Divide by zero: ready at T+2.
        issue("divu_zero", 3'b101, 32'd1234, 32'd0, 5'd10);
        run("divu_zero", 1, 3'b101, 32'd1234, 32'd0, 5'd10);
        finish("divu_zero", 32'hFFFF_FFFF, 5'd10, 1'b1);
        step();
        issue("remu_zero", 3'b111, 32'd1234, 32'd0, 5'd11);
        run("remu_zero", 1, 3'b111, 32'd1234, 32'd0, 5'd11);
        finish("remu_zero", 32'd1234, 5'd11, 1'b1);
        step();

        // Back-to-back: x3 then x4; second op waits while divider is busy.
        issue("b2b_x3", 3'b100, 32'd20, 32'd4, 5'd3);
        run("b2b_x3", 34, 3'b100, 32'd20, 32'd4, 5'd3);
        div_ready_i = 1'b1;
        div_busy_i  = 1'b0;
        div_res_i   = 32'd5;
        div_waddr_i = 5'd3;
        #1;
        check("b2b_x3_we", {27'd0, wb_we_o, wb_waddr_o}, {27'd0, 1'b1, 5'd3});
        check("b2b_x3_start", {31'd0, div_start_o}, 32'd0);
        step();
        div_ready_i = 1'b0;
        ex_valid_i  = 1'b1;
        ex_is_div_i = 1'b1;
        ex_funct3_i = 3'b100;
        ex_rs1_i    = 32'd30;
        ex_rs2_i    = 32'd6;
        ex_rd_i     = 5'd4;
        div_busy_i  = 1'b1;
        #1;
        check("b2b_busy_hold", {30'd0, div_start_o, stall_o}, 32'd1);
        step();
        #1;
        check("b2b_busy_still_idle", {30'd0, div_start_o, stall_o}, 32'd1);
        issue("b2b_x4", 3'b100, 32'd30, 32'd6, 5'd4);
        run("b2b_x4", 34, 3'b100, 32'd30, 32'd6, 5'd4);
        finish("b2b_x4", 32'd5, 5'd4, 1'b1);
        step();

        // Flush 10 cycles in, with a ready arriving during ABORT.
        issue("flush_op", 3'b100, 32'd50, 32'd5, 5'd12);
        run("flush_op", 9, 3'b100, 32'd50, 32'd5, 5'd12);
        flush_i    = 1'b1;
        div_busy_i = 1'b1;
        #1;
        check("flush_cycle", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd2);
        step();
        flush_i     = 1'b0;
        ex_valid_i  = 1'b0;
        div_ready_i = 1'b1;
        div_waddr_i = 5'd12;
        div_res_i   = 32'd10;
        #1;
        check("abort_ready_ignored", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd2);
        step();
        div_ready_i = 1'b0;
        #1;
        check("abort_busy", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd2);
        step();
        div_busy_i = 1'b0;
        #1;
        check("abort_busy_low", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd2);
        step();
        #1;
        check("abort_to_idle", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd0);
        issue("div9_3", 3'b100, 32'd9, 32'd3, 5'd13);
        run("div9_3", 34, 3'b100, 32'd9, 32'd3, 5'd13);
        finish("div9_3", 32'd3, 5'd13, 1'b1);
        step();

        // rd = x0: full stall, never writes.
        issue("rd_x0", 3'b100, 32'd77, 32'd7, 5'd0);
        run("rd_x0", 34, 3'b100, 32'd77, 32'd7, 5'd0);
        finish("rd_x0", 32'd11, 5'd0, 1'b0);
        step();

        // Reset mid-RUN.
        issue("rst_mid", 3'b101, 32'd99, 32'd9, 5'd14);
        run("rst_mid", 5, 3'b101, 32'd99, 32'd9, 5'd14);
        rst        = 1'b1;
        ex_valid_i = 1'b0;
        step();
        rst         = 1'b0;
        div_busy_i  = 1'b0;
        div_ready_i = 1'b1;
        div_waddr_i = 5'd14;
        #1;
        check("rst_mid_idle", {29'd0, div_start_o, stall_o, wb_we_o}, 32'd0);
        div_ready_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage sequencer for the iterative RV32M divider. It detects DIV/DIVU/REM/REMU in EX, drives the divider's operand, start and address inputs, and holds `start` high for the whole operation. It stalls the pipeline until the divider reports ready, then presents the result to the register-file write port. It also handles pipeline flushes by aborting the divider cleanly.

## Interface
Parameters:
- `DATA_W`, 32, operand and result width.
- `ADDR_W`, 5, register address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `ex_valid_i`  in  1  EX holds a valid instruction.
- `ex_is_div_i`  in  1  instruction is an M-extension op with funct3[2]=1.
- `ex_funct3_i`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `ex_rs1_i`  in  DATA_W  dividend.
- `ex_rs2_i`  in  DATA_W  divisor.
- `ex_rd_i`  in  ADDR_W  destination register.
- `flush_i`  in  1  kill the in-flight EX instruction.
- `div_start_o`  out  1  to divider `start_i`.
- `div_dividend_o`  out  DATA_W  to divider.
- `div_divisor_o`  out  DATA_W  to divider.
- `div_op_o`  out  3  to divider.
- `div_waddr_o`  out  ADDR_W  to divider.
- `div_ready_i`  in  1  divider result valid (1-cycle pulse).
- `div_busy_i`  in  1  divider busy.
- `div_res_i`  in  DATA_W  divider result.
- `div_waddr_i`  in  ADDR_W  divider's latched rd.
- `stall_o`  out  1  freeze PC, IF/ID and ID/EX.
- `wb_we_o`  out  1  register-file write enable.
- `wb_waddr_o`  out  ADDR_W  write address.
- `wb_wdata_o`  out  DATA_W  write data.

## Operation
- Request: `req = ex_valid_i & ex_is_div_i & ~flush_i`.
- State machine with three states.
  - IDLE:
    - Go to RUN when `req & ~div_busy_i`.
    - If `req & div_busy_i`, stay in IDLE with `stall_o` high.
  - RUN:
    - On `div_ready_i`, go to IDLE.
    - Else on `flush_i`, go to ABORT.
    - Else stay in RUN.
  - ABORT:
    - Go to IDLE when `div_busy_i`=0.
- Operand registers `op_r`, `a_r`, `b_r` and `rd_r`:
  - Loaded in the IDLE→RUN transition cycle.
  - Held constant in RUN.
  - `div_dividend_o`, `div_divisor_o`, `div_op_o` and `div_waddr_o` are driven from the operand mux: the EX inputs in IDLE, the registers otherwise.
- `div_start_o` is combinational:
  - `(IDLE & req & ~div_busy_i) | (RUN & ~div_ready_i & ~flush_i)`.
  - It must be 0 in the ready cycle; otherwise the divider, returning to IDLE, would relatch and restart.
- `stall_o` is combinational:
  - `(IDLE & req) | (RUN & ~div_ready_i) | ABORT`.
  - It is not asserted by a flushed request.
- Writeback is combinational in the ready cycle:
  - `wb_we_o = RUN & div_ready_i & (div_waddr_i != 0)`.
  - `wb_waddr_o = div_waddr_i`.
  - `wb_wdata_o = div_res_i`.
  - rd=x0 executes fully but never writes.
- The divider owns all arithmetic: sign handling, divide-by-zero results and the overflow case. This block does no arithmetic.
- Flush in RUN: `div_start_o` drops the same cycle and the divider abandons the operation. No `wb_we_o` is produced for the killed op. A `div_ready_i` arriving while in ABORT is ignored.
- `div_ready_i` while in IDLE (spurious) is ignored and produces no write.

## Timing
- Reset values:
  - State IDLE.
  - All operand registers 0.
  - `div_start_o`, `stall_o` and `wb_we_o` are 0, as they are combinational from IDLE with no request.
- Issue cycle T: `div_start_o`=1 and `stall_o`=1; the divider latches operands at the T edge.
- Divisor zero: `div_ready_i` at T+2. The result is written that cycle and `stall_o` is 0 at T+2, so EX advances at the T+2 edge.
- Nonzero divisor: the divider takes 35 cycles. `div_ready_i` arrives at T+35 and the stall lasts 35 cycles. The controller never counts; it waits only on `div_ready_i`.
- Back-to-back divides: the next request is issuable at T+N+1, once the divider is idle; `div_busy_i`=0 in the ready cycle.
- Flush at cycle F in RUN: start is low at F, ABORT from F+1, IDLE once busy falls, typically F+2.
- Reset mid-operation returns to IDLE next edge with no writeback.

## Test plan
- DIV 100/7, rd=x5 → `stall_o` high 35 cycles; one `wb_we_o` pulse with waddr 5, data 14; `div_start_o` low in that cycle.
- REM −7 % 2 (0xFFFFFFF9, 2) → data 0xFFFFFFFF; DIV gives 0xFFFFFFFD; DIVU 0xFFFFFFF9/2 gives 0x7FFFFFFC.
- DIVU 1234/0 → ready at T+2, data 0xFFFFFFFF. REMU 1234/0 → 1234.
- Two consecutive DIVs to x3 and x4 → two writes with the correct rd each; no extra relaunch between them; the second starts only after busy=0.
- Flush 10 cycles into a DIV, then a new DIV 9/3 → no write for the first, ABORT until busy low, second writes 3.
- DIV with rd=x0 → full stall duration, `wb_we_o` never asserted; `rst` pulse mid-RUN → IDLE, outputs 0, no write.
